axi4lite_slave_fe: RTL
======================

# axi4lite_slave_fe

AXI4-Lite slave front-end for the timer subsystem. It sits between the AXI4-Lite bus and the timer register block. It replaces the always-ready, combinational toy decode with proper handshakes: independent AW/W capture, BVALID and RVALID held until the master accepts, and a decoded SLVERR path. Towards the register block it issues single-cycle `wr_en` and `rd_en` strobes and captures `rd_data` with a fixed 1-cycle latency.

## Interface
Parameters:
- `ADDR_W`, default 4: AXI address width; register index is `addr[ADDR_W-1:2]`.
- `DATA_W`, default 32: data width.
- `NUM_REGS`, default 4: number of implemented word registers, indices 0..NUM_REGS-1.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous reset, active-high.
- `AWVALID`/`AWREADY`  in/out  1 each; `AWADDR`  in  ADDR_W.
- `WVALID`/`WREADY`  in/out  1 each; `WDATA`  in  DATA_W; `WSTRB`  in  DATA_W/8.
- `BVALID`  out  1; `BREADY`  in  1; `BRESP`  out  2.
- `ARVALID`/`ARREADY`  in/out  1 each; `ARADDR`  in  ADDR_W.
- `RVALID`  out  1; `RREADY`  in  1; `RDATA`  out  DATA_W; `RRESP`  out  2.
- `wr_en`  out  1: one-cycle write strobe to the register block.
- `wr_addr`  out  ADDR_W; `wr_data`  out  DATA_W; `wr_strb`  out  DATA_W/8: all valid while `wr_en` is high.
- `rd_en`  out  1: one-cycle read strobe. `rd_addr`  out  ADDR_W: valid with `rd_en`.
- `rd_data`  in  DATA_W: sampled exactly one cycle after `rd_en`.

## Operation
- **Reset.** All outputs reset to 0, including the READY signals. After `rst` falls, AWREADY, WREADY and ARREADY go high the next cycle. Asserting `rst` mid-transaction abandons it: no response is issued and no strobe is emitted.
- **Write FSM** (W_IDLE, W_EXEC, W_RESP):
  - In W_IDLE, AWREADY is high until AW has been captured, and WREADY is high until W has been captured. The two may arrive in either order or in the same cycle.
  - When both are held, the FSM moves to W_EXEC.
  - In W_EXEC, `wr_en` is high for one cycle if the address is legal. The FSM then moves to W_RESP.
  - In W_RESP, BVALID is held with BRESP stable until BREADY. The FSM then returns to W_IDLE.
- **Read FSM** (R_IDLE, R_EXEC, R_CAP, R_RESP):
  - In R_IDLE, ARREADY is high. An AR handshake moves the FSM to R_EXEC.
  - In R_EXEC, `rd_en` is high for one cycle if the address is legal. The FSM then moves to R_CAP.
  - In R_CAP, `rd_data` is registered into RDATA. An illegal address gives RDATA=0.
  - In R_RESP, RVALID is held with RDATA and RRESP stable until RREADY. The FSM then returns to R_IDLE.
- **Legality.** An address is legal when `addr[ADDR_W-1:2] < NUM_REGS`. `addr[1:0]` is ignored and passed through.
- **Arbitration.** If W_EXEC and R_EXEC would coincide, the write goes first and R_EXEC stalls one cycle. A read issued after a write's B handshake always returns the written value.
- **One outstanding transaction per channel.** While a channel is in its response state, its READY signals stay low.

## Timing
- **Write latency.** AW and W are both accepted at edge N. `wr_en` is high in cycle N+1. BVALID rises in cycle N+2 at the earliest.
- **Read latency.** AR is accepted at edge N. `rd_en` is high in cycle N+1. `rd_data` is sampled at the end of N+2. RVALID is high from cycle N+3.
- **Back-to-back.** BREADY or RREADY held high gives 1 idle cycle in IDLE between transactions. Write throughput is one transaction per 3 cycles; read throughput is one per 4 cycles.
- **Strobe width.** `wr_en` and `rd_en` are never high for two consecutive cycles.

## Configuration
- `AXIL_FE_SLVERR_EN` defined:
  - An illegal address returns BRESP or RRESP = 2'b10 (SLVERR).
  - No `wr_en` or `rd_en` strobe is issued for it.
- `AXIL_FE_SLVERR_EN` undefined:
  - Every response is 2'b00 (OKAY).
  - Strobes are always issued with the raw address, so the register block aliases the address.

## Structure
- Package `axil_fe_pkg` holds:
  - `resp_t` (OKAY=2'b00, SLVERR=2'b10);
  - the `wr_state_t` and `rd_state_t` enums;
  - the default constants.
- Sub-module `axil_fe_rd_ch` holds the read FSM. It takes a `stall` input driven by the write path's W_EXEC.

## Test plan
- **Write, W before AW.** WDATA=0x0000_00FF arrives at cycle 0, AWADDR=0x4 at cycle 3 -> one `wr_en` pulse with wr_addr=0x4 and wr_data=0xFF, then BVALID with BRESP=00.
- **BREADY backpressure.** BREADY is held low for 5 cycles -> BVALID stays high with BRESP stable, AWREADY=0, and no second `wr_en`.
- **Read.** ARADDR=0x8, with `rd_data`=0xDEAD_BEEF driven in the cycle after `rd_en` -> RDATA=0xDEADBEEF and RVALID at N+3.
- **Simultaneous write and read.** Write to 0x0 and read of 0x0 complete in the same cycle -> `wr_en` comes one cycle before `rd_en`, and the two are never high together.
- **Illegal address.** ARADDR=0xC with NUM_REGS=3 and SLVERR enabled -> no `rd_en`, RRESP=10, RDATA=0. With the macro undefined -> `rd_en` is issued and RRESP=00.
- **Reset mid-read.** `rst` is asserted in R_CAP -> RVALID never rises, all outputs are 0, and ARREADY=1 one cycle after `rst` deasserts.

Source files
------------

// File: rtl/axil_fe_pkg.sv
// -----------------------------------------------------------------------------
// axil_fe_pkg
// Shared types and constants for the AXI4-Lite slave front-end.
//   resp_t      : AXI response codes (OKAY / SLVERR)
//   wr_state_t  : write channel FSM states
//   rd_state_t  : read channel FSM states
// Build option: define AXIL_FE_SLVERR_EN to answer illegal register indices
// with SLVERR and suppress the register-block strobe. Without it every
// response is OKAY and the raw address is forwarded (the block aliases).
// -----------------------------------------------------------------------------
package axil_fe_pkg;

   localparam int unsigned AXIL_FE_ADDR_W   = 4;
   localparam int unsigned AXIL_FE_DATA_W   = 32;
   localparam int unsigned AXIL_FE_NUM_REGS = 4;

`ifdef AXIL_FE_SLVERR_EN
   localparam bit AXIL_FE_SLVERR = 1'b1;
`else
   localparam bit AXIL_FE_SLVERR = 1'b0;
`endif

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_EXEC = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_EXEC = 2'd1,
      R_CAP  = 2'd2,
      R_RESP = 2'd3
   } rd_state_t;

   // A register index is implemented when it is below the register count.
   function automatic logic idx_legal(input logic [31:0] idx, input int unsigned num_regs);
      return (idx < num_regs);
   endfunction

   // Map "access may proceed" onto the AXI response code.
   function automatic resp_t resp_for(input logic ok);
      return ok ? RESP_OKAY : RESP_SLVERR;
   endfunction

endpackage

// File: rtl/axil_fe_rd_ch.sv
// -----------------------------------------------------------------------------
// axil_fe_rd_ch
// Read channel of the AXI4-Lite front-end: AR capture, one-cycle rd_en strobe,
// rd_data capture one cycle later, RVALID held until RREADY.
// Ports: clk/rst (sync, active-high); AR channel (ARVALID/ARREADY/ARADDR);
//        R channel (RVALID/RREADY/RDATA/RRESP); register side (rd_en,
//        rd_addr, rd_data); stall holds R_EXEC while the write path strobes.
// Build option: AXIL_FE_SLVERR_EN (see axil_fe_pkg).
// -----------------------------------------------------------------------------
module axil_fe_rd_ch
   import axil_fe_pkg::*;
#(
   parameter int unsigned ADDR_W   = AXIL_FE_ADDR_W,
   parameter int unsigned DATA_W   = AXIL_FE_DATA_W,
   parameter int unsigned NUM_REGS = AXIL_FE_NUM_REGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ARVALID,
   output logic              ARREADY,
   input  logic [ADDR_W-1:0] ARADDR,
   output logic              RVALID,
   input  logic              RREADY,
   output logic [DATA_W-1:0] RDATA,
   output logic [1:0]        RRESP,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              stall
);

   rd_state_t         r_state_q, r_state_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   resp_t             rresp_q, rresp_d;
   logic              arready_q;
   logic              ar_fire_s;
   logic              rd_ok_s;

   assign ar_fire_s = ARVALID && arready_q;
   // Without SLVERR support every address is forwarded as-is.
   assign rd_ok_s   = !AXIL_FE_SLVERR || idx_legal(32'(araddr_q[ADDR_W-1:2]), NUM_REGS);

   // Next-state and capture logic for the read FSM.
   always_comb begin
      r_state_d = r_state_q;
      araddr_d  = araddr_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_fire_s) begin
               araddr_d  = ARADDR;
               r_state_d = R_EXEC;
            end else begin
               r_state_d = R_IDLE;
            end
         end
         R_EXEC: begin
            // The write strobe owns this cycle; retry the read next cycle.
            if (!stall) begin
               r_state_d = R_CAP;
            end else begin
               r_state_d = R_EXEC;
            end
         end
         R_CAP: begin
            rdata_d   = rd_ok_s ? rd_data : {DATA_W{1'b0}};
            rresp_d   = resp_for(rd_ok_s);
            r_state_d = R_RESP;
         end
         R_RESP: begin
            if (RREADY) begin
               r_state_d = R_IDLE;
            end else begin
               r_state_d = R_RESP;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // State and data registers; ARREADY is registered so it is low in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         araddr_q  <= {ADDR_W{1'b0}};
         rdata_q   <= {DATA_W{1'b0}};
         rresp_q   <= RESP_OKAY;
         arready_q <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         araddr_q  <= araddr_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         arready_q <= (r_state_d == R_IDLE);
      end
   end

   assign ARREADY = arready_q;
   assign RVALID  = (r_state_q == R_RESP);
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign rd_en   = (r_state_q == R_EXEC) && !stall && rd_ok_s;
   assign rd_addr = araddr_q;

endmodule

// File: rtl/axi4lite_slave_fe.sv
// -----------------------------------------------------------------------------
// axi4lite_slave_fe
// AXI4-Lite slave front-end for the timer register block. Captures AW and W
// independently, issues a one-cycle wr_en strobe, holds BVALID until BREADY;
// the read channel lives in axil_fe_rd_ch and is stalled for one cycle when
// a write strobe would collide with the read strobe (write wins).
// Ports: clk/rst (sync, active-high); AXI4-Lite AW/W/B/AR/R channels;
//        register side wr_en/wr_addr/wr_data/wr_strb, rd_en/rd_addr/rd_data.
// Build option: AXIL_FE_SLVERR_EN (see axil_fe_pkg).
// -----------------------------------------------------------------------------
module axi4lite_slave_fe
   import axil_fe_pkg::*;
#(
   parameter int unsigned ADDR_W   = AXIL_FE_ADDR_W,
   parameter int unsigned DATA_W   = AXIL_FE_DATA_W,
   parameter int unsigned NUM_REGS = AXIL_FE_NUM_REGS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                AWVALID,
   output logic                AWREADY,
   input  logic [ADDR_W-1:0]   AWADDR,
   input  logic                WVALID,
   output logic                WREADY,
   input  logic [DATA_W-1:0]   WDATA,
   input  logic [DATA_W/8-1:0] WSTRB,
   output logic                BVALID,
   input  logic                BREADY,
   output logic [1:0]          BRESP,
   input  logic                ARVALID,
   output logic                ARREADY,
   input  logic [ADDR_W-1:0]   ARADDR,
   output logic                RVALID,
   input  logic                RREADY,
   output logic [DATA_W-1:0]   RDATA,
   output logic [1:0]          RRESP,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]   wr_data,
   output logic [DATA_W/8-1:0] wr_strb,
   output logic                rd_en,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic [DATA_W-1:0]   rd_data
);

   wr_state_t           w_state_q, w_state_d;
   logic                aw_held_q, aw_held_d;
   logic                w_held_q, w_held_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   resp_t               bresp_q, bresp_d;
   logic                awready_q, wready_q;
   logic                aw_fire_s, w_fire_s, wr_ok_s, stall_s;

   assign aw_fire_s = AWVALID && awready_q;
   assign w_fire_s  = WVALID && wready_q;
   assign wr_ok_s   = !AXIL_FE_SLVERR || idx_legal(32'(awaddr_q[ADDR_W-1:2]), NUM_REGS);
   assign stall_s   = (w_state_q == W_EXEC);

   // Next-state and capture logic for the write FSM.
   always_comb begin
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_IDLE: begin
            if (aw_fire_s) begin
               aw_held_d = 1'b1;
               awaddr_d  = AWADDR;
            end else begin
               aw_held_d = aw_held_q;
            end
            if (w_fire_s) begin
               w_held_d = 1'b1;
               wdata_d  = WDATA;
               wstrb_d  = WSTRB;
            end else begin
               w_held_d = w_held_q;
            end
            // Either order, or both in the same cycle.
            if (aw_held_d && w_held_d) begin
               w_state_d = W_EXEC;
            end else begin
               w_state_d = W_IDLE;
            end
         end
         W_EXEC: begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bresp_d   = resp_for(wr_ok_s);
            w_state_d = W_RESP;
         end
         W_RESP: begin
            if (BREADY) begin
               w_state_d = W_IDLE;
            end else begin
               w_state_d = W_RESP;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // State and capture registers; READYs are registered so they are low in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= {ADDR_W{1'b0}};
         wdata_q   <= {DATA_W{1'b0}};
         wstrb_q   <= {(DATA_W/8){1'b0}};
         bresp_q   <= RESP_OKAY;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         awready_q <= (w_state_d == W_IDLE) && !aw_held_d;
         wready_q  <= (w_state_d == W_IDLE) && !w_held_d;
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = (w_state_q == W_RESP);
   assign BRESP   = bresp_q;
   assign wr_en   = (w_state_q == W_EXEC) && wr_ok_s;
   assign wr_addr = awaddr_q;
   assign wr_data = wdata_q;
   assign wr_strb = wstrb_q;

   axil_fe_rd_ch #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_rd_ch (
      .clk     (clk),
      .rst     (rst),
      .ARVALID (ARVALID),
      .ARREADY (ARREADY),
      .ARADDR  (ARADDR),
      .RVALID  (RVALID),
      .RREADY  (RREADY),
      .RDATA   (RDATA),
      .RRESP   (RRESP),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .stall   (stall_s)
   );

endmodule
